// File: rtl/mem_stage.sv
// mem_stage: dual-lane memory stage. Holds the EX/MEM and MEM/WB registers for
// both lanes and shares one synchronous data-memory port between them. A bundle
// in which both lanes need memory is split over two cycles, lane 1 first.
// Optional macro MEM_ST_LD_FWD_EN: a lane-1 store followed by a lane-2 load of
// the same word completes in one cycle by forwarding the store data to lane 2.
module mem_stage #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_RegWrite1E,
  input  logic          i_MemtoReg1E,
  input  logic          i_MemWrite1E,
  input  logic [DW-1:0] i_ALUResult1E,
  input  logic [DW-1:0] i_WriteData1E,
  input  logic [3:0]    i_WA1E,
  input  logic          i_RegWrite2E,
  input  logic          i_MemtoReg2E,
  input  logic          i_MemWrite2E,
  input  logic [DW-1:0] i_ALUResult2E,
  input  logic [DW-1:0] i_WriteData2E,
  input  logic [3:0]    i_WA2E,
  input  logic          i_FlushM,
  output logic          o_StallM,
  output logic [DW-1:0] o_ALUResult1M,
  output logic [DW-1:0] o_ALUResult2M,
  output logic [3:0]    o_WA1M,
  output logic [3:0]    o_WA2M,
  output logic          o_RegWrite1M,
  output logic          o_RegWrite2M,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic          dmem_we,
  output logic          dmem_re,
  input  logic [DW-1:0] dmem_rdata,
  output logic          o_RegWrite1W,
  output logic          o_MemtoReg1W,
  output logic [DW-1:0] o_ALUResult1W,
  output logic [DW-1:0] o_ReadData1W,
  output logic [3:0]    o_WA1W,
  output logic          o_RegWrite2W,
  output logic          o_MemtoReg2W,
  output logic [DW-1:0] o_ALUResult2W,
  output logic [DW-1:0] o_ReadData2W,
  output logic [3:0]    o_WA2W
);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t state, state_next;

  logic          reg_write1_m, mem_to_reg1_m, mem_write1_m;
  logic [DW-1:0] alu_result1_m, write_data1_m;
  logic [3:0]    wa1_m;
  logic          reg_write2_m, mem_to_reg2_m, mem_write2_m;
  logic [DW-1:0] alu_result2_m, write_data2_m;
  logic [3:0]    wa2_m;

  logic          reg_write1_w, mem_to_reg1_w;
  logic [DW-1:0] alu_result1_w;
  logic [3:0]    wa1_w;
  logic          reg_write2_w, mem_to_reg2_w;
  logic [DW-1:0] alu_result2_w;
  logic [3:0]    wa2_w;

  logic          load1_m, load2_m, mem1, mem2, conflict;
  logic          keep1, keep2;
  logic [AW-1:0] addr1_m, addr2_m;

  assign load1_m = mem_to_reg1_m & reg_write1_m;
  assign load2_m = mem_to_reg2_m & reg_write2_m;
  assign mem1    = mem_write1_m | load1_m;
  assign mem2    = mem_write2_m | load2_m;
  assign addr1_m = alu_result1_m[AW+1:2];
  assign addr2_m = alu_result2_m[AW+1:2];

`ifdef MEM_ST_LD_FWD_EN
  logic          fwd_hit;
  logic          fwd_w;
  logic [DW-1:0] fwd_data_w;

  assign fwd_hit  = (state == IDLE) & mem_write1_m & load2_m & (addr1_m == addr2_m);
  assign conflict = (state == IDLE) & mem1 & mem2 & ~fwd_hit;
`else
  assign conflict = (state == IDLE) & mem1 & mem2;
`endif

  assign o_StallM = conflict;

  // In the split cycle only lane 2 is real; in the conflict cycle only lane 1.
  assign keep1 = (state == IDLE);
  assign keep2 = ~conflict;

  // Conflict state register; a reset drops any pending lane-2 access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Split for exactly one extra cycle after a conflict.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (conflict) state_next = SPLIT;
      SPLIT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // EX/MEM register: holds during a stall, flush only bubbles a fresh capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write1_m  <= 1'b0;
      mem_to_reg1_m <= 1'b0;
      mem_write1_m  <= 1'b0;
      alu_result1_m <= '0;
      write_data1_m <= '0;
      wa1_m         <= '0;
      reg_write2_m  <= 1'b0;
      mem_to_reg2_m <= 1'b0;
      mem_write2_m  <= 1'b0;
      alu_result2_m <= '0;
      write_data2_m <= '0;
      wa2_m         <= '0;
    end else if (!o_StallM) begin
      reg_write1_m  <= i_RegWrite1E & ~i_FlushM;
      mem_to_reg1_m <= i_MemtoReg1E & ~i_FlushM;
      mem_write1_m  <= i_MemWrite1E & ~i_FlushM;
      alu_result1_m <= i_ALUResult1E;
      write_data1_m <= i_WriteData1E;
      wa1_m         <= i_WA1E;
      reg_write2_m  <= i_RegWrite2E & ~i_FlushM;
      mem_to_reg2_m <= i_MemtoReg2E & ~i_FlushM;
      mem_write2_m  <= i_MemWrite2E & ~i_FlushM;
      alu_result2_m <= i_ALUResult2E;
      write_data2_m <= i_WriteData2E;
      wa2_m         <= i_WA2E;
    end
  end

  // Port steering: the split cycle serves lane 2, otherwise lane 1 has priority.
  always_comb begin
    dmem_we    = 1'b0;
    dmem_re    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    if (state == SPLIT) begin
      if (mem2) begin
        dmem_we    = mem_write2_m;
        dmem_re    = load2_m;
        dmem_addr  = addr2_m;
        dmem_wdata = write_data2_m;
      end
    end else if (mem1) begin
      dmem_we    = mem_write1_m;
      dmem_re    = load1_m;
      dmem_addr  = addr1_m;
      dmem_wdata = write_data1_m;
    end else if (mem2) begin
      dmem_we    = mem_write2_m;
      dmem_re    = load2_m;
      dmem_addr  = addr2_m;
      dmem_wdata = write_data2_m;
    end
  end

  // MEM/WB register: lanes not served this cycle arrive with controls cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write1_w  <= 1'b0;
      mem_to_reg1_w <= 1'b0;
      alu_result1_w <= '0;
      wa1_w         <= '0;
      reg_write2_w  <= 1'b0;
      mem_to_reg2_w <= 1'b0;
      alu_result2_w <= '0;
      wa2_w         <= '0;
    end else begin
      reg_write1_w  <= reg_write1_m & keep1;
      mem_to_reg1_w <= mem_to_reg1_m & keep1;
      alu_result1_w <= alu_result1_m;
      wa1_w         <= wa1_m;
      reg_write2_w  <= reg_write2_m & keep2;
      mem_to_reg2_w <= mem_to_reg2_m & keep2;
      alu_result2_w <= alu_result2_m;
      wa2_w         <= wa2_m;
    end
  end

`ifdef MEM_ST_LD_FWD_EN
  // Registered store data for a same-word store/load pair resolved without memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_w      <= 1'b0;
      fwd_data_w <= '0;
    end else begin
      fwd_w      <= fwd_hit;
      fwd_data_w <= write_data1_m;
    end
  end

  assign o_ReadData2W = fwd_w ? fwd_data_w :
                        ((reg_write2_w & mem_to_reg2_w) ? dmem_rdata : '0);
`else
  assign o_ReadData2W = (reg_write2_w & mem_to_reg2_w) ? dmem_rdata : '0;
`endif

  assign o_ReadData1W  = (reg_write1_w & mem_to_reg1_w) ? dmem_rdata : '0;

  assign o_ALUResult1M = alu_result1_m;
  assign o_ALUResult2M = alu_result2_m;
  assign o_WA1M        = wa1_m;
  assign o_WA2M        = wa2_m;
  assign o_RegWrite1M  = reg_write1_m;
  assign o_RegWrite2M  = reg_write2_m;

  assign o_RegWrite1W  = reg_write1_w;
  assign o_MemtoReg1W  = mem_to_reg1_w;
  assign o_ALUResult1W = alu_result1_w;
  assign o_WA1W        = wa1_w;
  assign o_RegWrite2W  = reg_write2_w;
  assign o_MemtoReg2W  = mem_to_reg2_w;
  assign o_ALUResult2W = alu_result2_w;
  assign o_WA2W        = wa2_w;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Dual-lane memory stage directly downstream of the execute stage.
- Holds the EX/MEM pipeline register for both lanes and drives a single-ported synchronous data memory.
- Holds the MEM/WB register feeding writeback.
- When both lanes of a bundle need memory, the block serializes them over two cycles: lane 1 first, then lane 2. It stalls upstream while doing so.

Parameters:
- DW, 32, data/address width.
- AW, 10, data-memory word-address width; the address is ALUResult[AW+1:2].

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_RegWrite1E, i_MemtoReg1E, i_MemWrite1E  in  1 each  lane-1 controls, already condition-qualified
- i_ALUResult1E, i_WriteData1E  in  DW each  lane-1 address/result, store data
- i_WA1E  in  4  lane-1 destination register
- i_RegWrite2E, i_MemtoReg2E, i_MemWrite2E, i_ALUResult2E, i_WriteData2E, i_WA2E  in  same widths as lane 1  lane-2 equivalents
- i_FlushM  in  1  capture a bubble into M instead of the E inputs
- o_StallM  out  1  upstream must hold E-stage contents this cycle
- o_ALUResult1M, o_ALUResult2M  out  DW  M-register results, for forwarding
- o_WA1M, o_WA2M  out  4  M-register destinations, for hazard detection
- o_RegWrite1M, o_RegWrite2M  out  1  M-register write enables, for hazard detection
- dmem_addr  out  AW  data-memory word address
- dmem_wdata  out  DW  store data
- dmem_we  out  1  write strobe
- dmem_re  out  1  read strobe
- dmem_rdata  in  DW  read data, valid the cycle after dmem_re
- o_RegWrite1W, o_MemtoReg1W  out  1  lane-1 writeback controls
- o_ALUResult1W, o_ReadData1W  out  DW  lane-1 writeback data
- o_WA1W  out  4  lane-1 writeback destination
- o_RegWrite2W, o_MemtoReg2W, o_ALUResult2W, o_ReadData2W, o_WA2W  out  same widths as lane 1  lane-2 equivalents

Behaviour:
- Lane memory-op definition: memN = MemWriteNM | (MemtoRegNM & RegWriteNM). Loads are defined as MemtoReg & RegWrite.
- Conflict: conflict = mem1 & mem2 while the FSM is in IDLE.
- FSM states and transitions:
  - IDLE goes to SPLIT on conflict.
  - SPLIT goes to IDLE unconditionally.
  - Reset state is IDLE.
- o_StallM = conflict (IDLE only). It is combinational from M-register contents and FSM state.
- M-register capture rules:
  - Captures E inputs every cycle with o_StallM=0.
  - Holds while o_StallM=1.
  - i_FlushM with o_StallM=0 captures all controls as 0; data fields are don't-care.
  - i_FlushM while stalled is ignored; the held bundle is older than the flush source.
- Memory port drive, by state:
  - IDLE without conflict: whichever lane has a memory op drives the port; at most one can.
  - IDLE with conflict: lane 1 drives the port.
  - SPLIT: lane 2 drives the port.
- Memory port signals:
  - dmem_we = MemWrite of the selected lane.
  - dmem_re = its load.
  - dmem_addr/dmem_wdata come from that lane.
  - With no access, dmem_we and dmem_re are 0; dmem_addr and dmem_wdata are 0.
- W-register capture, every cycle:
  - IDLE with conflict: lane 1 real, lane 2 controls zeroed.
  - SPLIT: lane 1 controls zeroed, lane 2 real.
  - Otherwise: both lanes copied from M.
- Writeback read data: o_ReadDataNW = dmem_rdata on the lane whose W copy is a load, else 0. Since only one access occurs per cycle, no lane-select register is needed beyond the W controls.
- Latency: E to W is 2 cycles without conflict, 3 cycles for lane 2 on conflict.
- Reset: FSM IDLE; all M and W registers and all outputs reset to 0; o_StallM=0.
- Reset mid-SPLIT: return to IDLE; the pending lane-2 access is dropped.
- A bundle with only one memory op, or none, never stalls.
- Back-to-back conflicting bundles each take 2 cycles, giving throughput of 1 bundle per 2 cycles.

Optional Feature:
- Macro: MEM_ST_LD_FWD_EN.
- Defined, single-cycle case: lane 1 is a store, lane 2 is a load, and dmem_addr values match (word compare). The bundle takes one cycle with no stall:
  - lane 1 store is issued to the port;
  - o_ReadData2W in the following cycle = lane-1 store data, registered;
  - lane 2 does not access memory.
- Defined, all other conflicts: serialize as above.
- Undefined: every conflict serializes; no comparator is built.

Test Plan:
- Lane 1 load from addr 0x40 (mem holds 0xDEAD), lane 2 ALU op writing 0x5 to r3 -> no stall; next cycle o_ReadData1W=0xDEAD, o_MemtoReg1W=1, o_ALUResult2W=0x5, o_WA2W=3.
- Lane 1 store 0x11 to addr 0x10, lane 2 load addr 0x20 (0x22) -> o_StallM=1 one cycle, dmem_we=1 @word 4, then dmem_re @word 8; W shows lane 1 only, then lane 2 only with o_ReadData2W=0x22.
- Same bundle as previous, with MEM_ST_LD_FWD_EN defined and lane 2 loading 0x10 -> no stall, o_ReadData2W=0x11.
- i_FlushM=1 while o_StallM=1 -> held bundle still completes both accesses; i_FlushM=1 while o_StallM=0 -> next W has all write enables 0.
- Assert rst while in SPLIT -> outputs 0 immediately, FSM IDLE, no lane-2 access after release.
- Three consecutive conflicting bundles -> o_StallM pattern 1,0,1,0,1,0; six memory accesses strictly in order lane1, lane2 per bundle.
